gpio_in: RTL

GPIO_IN -- requirements
Module: gpio_in

---
 rtl/gpio_in.sv | 97 +++++++++
 1 files changed

// File: rtl/gpio_in.sv
// Four-pin active-low GPIO input block: 2-FF synchronizer, optional per-pin debounce
// (enabled by macro GPIO_IN_DEBOUNCE_EN), press-edge capture with W1C, and interrupt enables.
module gpio_in #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [3:0]  gpio,
  output logic [31:0] q,
  output logic        irq
);

  localparam logic [7:0] ADDR_DATA = 8'h00;
  localparam logic [7:0] ADDR_EDGE = 8'h04;
  localparam logic [7:0] ADDR_IE   = 8'h08;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_param_check
    $error("gpio_in: DEBOUNCE_CYCLES must be in 1..65535");
  end

  logic [3:0] sync1, sync2, stable, stable_next;
  logic [3:0] edge_q, ie_q;
  logic [3:0] edge_set, edge_clr;
  logic       wr_edge, wr_ie;

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [3:0][15:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    stable_next = stable;
    cnt_d       = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2[i] == stable[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_next[i] = sync2[i];
        cnt_d[i]       = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign stable_next = sync2;
`endif

  // A press is DATA going 0->1, i.e. the active-low stable level falling.
  assign edge_set = stable & ~stable_next;
  assign wr_edge  = we && be[0] && (addr == ADDR_EDGE);
  assign wr_ie    = we && be[0] && (addr == ADDR_IE);
  assign edge_clr = wr_edge ? wdata[3:0] : 4'h0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 4'hF;
      sync2  <= 4'hF;
      stable <= 4'hF;
      edge_q <= 4'h0;
      ie_q   <= 4'h0;
    end else begin
      sync1  <= gpio;
      sync2  <= sync1;
      stable <= stable_next;
      edge_q <= (edge_q & ~edge_clr) | edge_set;
      if (wr_ie) ie_q <= wdata[3:0];
    end
  end

  always_comb begin
    q = '0;
    unique case (addr)
      ADDR_DATA: q[3:0] = ~stable;
      ADDR_EDGE: q[3:0] = edge_q;
      ADDR_IE:   q[3:0] = ie_q;
      default:   q      = '0;
    endcase
  end

  assign irq = |(edge_q & ie_q);

  logic unused_bits;
  assign unused_bits = ^{wdata[31:4], be[3:1]};

endmodule
